joy_sample_framer: RTL and testbench
====================================

Name: joy_sample_framer

Overview:
- Upstream stage of the joystick position logic.
- Consumes bytes from the UART receiver, which runs in the baud-clock domain. Drives the select line that tells the microcontroller which axis to send.
- Assembles an atomic (vx, vy) pair and publishes it with a one-cycle valid strobe.
- Replaces the free-toggling select: adds axis sequencing, a byte-arrival timeout and error counting, so an X byte is never latched as Y.

Parameters:
- TIMEOUT_CYC, 2_000_000: clk_i cycles to wait for a byte before declaring a timeout (20 ms at 100 MHz).
- SETTLE_CYC, 16: clk_i cycles sel_o is held after changing before bytes are accepted.
- CENTER, 8'h80: reset/idle value of both axis outputs.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset; already debounced by the caller.
- byte_i  in  8  received byte from uart_rx; stable while ready_i is high.
- ready_i  in  1  uart_rx ready level, asynchronous to clk_i.
- sel_o  out  1  axis request to the microcontroller: 0 = X, 1 = Y.
- vx_o  out  8  latest complete X sample.
- vy_o  out  8  latest complete Y sample.
- valid_o  out  1  one-cycle pulse when vx_o/vy_o update together.
- timeout_o  out  1  one-cycle pulse on a byte timeout.
- err_cnt_o  out  8  saturating count of timeouts.

Behaviour:
- Reset (rst_i low, asynchronous): state = REQ_X, sel_o = 0, vx_o = vy_o = CENTER, valid_o = 0, timeout_o = 0, err_cnt_o = 0, synchronizer flops = 0, counters = 0.
- ready_i passes through a 2-flop synchronizer, then a rising-edge detector. byte_strb is high for one cycle, 3 cycles after the ready_i rise.
- byte_i is sampled in the byte_strb cycle into a holding register.
- FSM states: REQ_X, WAIT_X, REQ_Y, WAIT_Y, PUBLISH.
  - REQ_X: sel_o = 0; settle counter counts SETTLE_CYC cycles, then go to WAIT_X. byte_strb is ignored here.
  - WAIT_X: on byte_strb, latch the byte into x_hold and go to REQ_Y. If the timeout counter reaches TIMEOUT_CYC-1 first, go to REQ_X.
  - REQ_Y: sel_o = 1; settle for SETTLE_CYC cycles, then go to WAIT_Y. byte_strb is ignored.
  - WAIT_Y: on byte_strb, latch into y_hold and go to PUBLISH. On timeout, go to REQ_X.
  - PUBLISH (one cycle): vx_o <= x_hold, vy_o <= y_hold, valid_o = 1 the following cycle, then go to REQ_X.
- The timeout counter clears on entry to each WAIT state and counts only in WAIT states.
- On a timeout:
  - timeout_o pulses for 1 cycle.
  - err_cnt_o increments, saturating at 8'hFF.
  - Any partial x_hold is discarded; vx_o/vy_o keep their previous values.
- If byte_strb and timeout occur in the same cycle, the byte wins and no timeout is counted.
- Latency: from the byte_strb of the Y byte to valid_o is 2 cycles.
- Minimum pair period: 2*SETTLE_CYC + 2 cycles plus the arrival times.
- Reset asserted mid-pair: all state is lost immediately. After release, sequencing restarts at REQ_X.

Optional Feature:
- Macro: JOY_CENTER_CAL_EN.
- When defined:
  - The first pair published after reset is not output (valid_o stays low). It is stored as offsets off_x, off_y.
  - Each later pair outputs clamp(raw - off + CENTER) into 0..255, computed with 10-bit signed arithmetic.
- When undefined: raw bytes pass through unchanged and the first pair is published normally.

Decomposition:
- Shared package joy_pkg holds the FSM state enum (joy_frame_state_t), the CENTER default, and the SEL_X = 0 / SEL_Y = 1 constants.
- One natural sub-module, sync_edge_det: 2-flop synchronizer plus rising-edge pulse generator, reusable for the debounced switch path.

Test Plan:
- Reset → sel_o = 0, vx_o = vy_o = 8'h80, err_cnt_o = 0, valid_o = 0.
- Normal pair: ready_i pulse with byte 8'h10 during WAIT_X, then 8'hF0 during WAIT_Y → sel_o goes 0→1→0; one valid_o pulse; vx_o = 8'h10, vy_o = 8'hF0.
- Byte during settle: ready_i pulse with 8'h55 within SETTLE_CYC cycles of entering REQ_Y → ignored; the FSM stays in WAIT_Y until the next byte, and vy_o takes only that later byte.
- Timeout: X byte 8'h20 sent, no Y byte for TIMEOUT_CYC cycles (override to 100) → timeout_o pulses, err_cnt_o = 1, sel_o returns to 0, vx_o/vy_o unchanged.
- Saturation: 300 consecutive timeouts → err_cnt_o = 8'hFF.
- JOY_CENTER_CAL_EN: first pair (8'h78, 8'h88) → no valid_o. Next pair (8'h78, 8'h00) → vx_o = 8'h80, vy_o = 8'h00 (clamped from -8).

Source files
------------

// File: rtl/joy_pkg.sv
// Shared types and constants for the joystick sample framer.
// cal_apply is used only when JOY_CENTER_CAL_EN is defined.
package joy_pkg;

  typedef enum logic [2:0] {
    REQ_X,
    WAIT_X,
    REQ_Y,
    WAIT_Y,
    PUBLISH
  } joy_frame_state_t;

  localparam logic [7:0] CENTER_DEF = 8'h80;
  localparam logic       SEL_X      = 1'b0;
  localparam logic       SEL_Y      = 1'b1;

  // raw - off + center, clamped to 0..255; the 10-bit sum holds -255..510
  function automatic logic [7:0] cal_apply(input logic [7:0] raw,
                                           input logic [7:0] off,
                                           input logic [7:0] center);
    logic signed [9:0] w_sum;
    w_sum = $signed({2'b00, raw}) - $signed({2'b00, off}) + $signed({2'b00, center});
    if (w_sum < 10'sd0) return 8'h00;
    if (w_sum > 10'sd255) return 8'hFF;
    return w_sum[7:0];
  endfunction

endpackage

// File: rtl/joy_sample_framer_sync_edge_det.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// The pulse is high for one cycle, three clocks after the input rises.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       r_pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b00;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_async};
      r_prev  <= r_sync[1];
      r_pulse <= r_sync[1] & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/joy_sample_framer.sv
// Sequences X/Y byte requests from the joystick MCU and publishes atomic pairs.
// Optional JOY_CENTER_CAL_EN: first pair after reset becomes the centre offset.
module joy_sample_framer
  import joy_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 2_000_000,
  parameter int         SETTLE_CYC  = 16,
  parameter logic [7:0] CENTER      = CENTER_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] byte_i,
  input  logic       ready_i,
  output logic       sel_o,
  output logic [7:0] vx_o,
  output logic [7:0] vy_o,
  output logic       valid_o,
  output logic       timeout_o,
  output logic [7:0] err_cnt_o
);

  localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
  localparam int            SW       = $clog2(SETTLE_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);

  logic             w_byte_strb;
  joy_frame_state_t r_state;
  logic [TW-1:0]    r_tmo_cnt;
  logic [SW-1:0]    r_settle_cnt;
  logic [7:0]       r_x_hold;
  logic [7:0]       r_y_hold;
  logic             r_sel;
  logic             r_valid;
  logic             r_timeout;
  logic [7:0]       r_vx;
  logic [7:0]       r_vy;
  logic [7:0]       r_err_cnt;
`ifdef JOY_CENTER_CAL_EN
  logic             r_cal_done;
  logic [7:0]       r_off_x;
  logic [7:0]       r_off_y;
`endif

  sync_edge_det u_ready_sync (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_async (ready_i),
    .o_pulse (w_byte_strb)
  );

  // Strobes arriving during a REQ settle window are dropped so a late X byte
  // can never be captured as Y.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= REQ_X;
      r_tmo_cnt    <= '0;
      r_settle_cnt <= '0;
      r_x_hold     <= CENTER;
      r_y_hold     <= CENTER;
      r_sel        <= SEL_X;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
      r_vx         <= CENTER;
      r_vy         <= CENTER;
      r_err_cnt    <= 8'h00;
`ifdef JOY_CENTER_CAL_EN
      r_cal_done   <= 1'b0;
      r_off_x      <= 8'h00;
      r_off_y      <= 8'h00;
`endif
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        REQ_X, REQ_Y: begin
          if (r_settle_cnt == SET_LAST) begin
            r_state   <= (r_state == REQ_X) ? WAIT_X : WAIT_Y;
            r_tmo_cnt <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        WAIT_X, WAIT_Y: begin
          if (w_byte_strb) begin
            r_settle_cnt <= '0;
            if (r_state == WAIT_X) begin
              r_x_hold <= byte_i;
              r_sel    <= SEL_Y;
              r_state  <= REQ_Y;
            end else begin
              r_y_hold <= byte_i;
              r_state  <= PUBLISH;
            end
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_state      <= REQ_X;
            r_sel        <= SEL_X;
            r_settle_cnt <= '0;
            r_timeout    <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        PUBLISH: begin
`ifdef JOY_CENTER_CAL_EN
          if (r_cal_done) begin
            r_vx    <= cal_apply(r_x_hold, r_off_x, CENTER);
            r_vy    <= cal_apply(r_y_hold, r_off_y, CENTER);
            r_valid <= 1'b1;
          end else begin
            r_off_x    <= r_x_hold;
            r_off_y    <= r_y_hold;
            r_cal_done <= 1'b1;
          end
`else
          r_vx    <= r_x_hold;
          r_vy    <= r_y_hold;
          r_valid <= 1'b1;
`endif
          r_state      <= REQ_X;
          r_sel        <= SEL_X;
          r_settle_cnt <= '0;
        end
        default: begin
          r_state      <= REQ_X;
          r_sel        <= SEL_X;
          r_settle_cnt <= '0;
        end
      endcase
    end
  end

  assign sel_o     = r_sel;
  assign vx_o      = r_vx;
  assign vy_o      = r_vy;
  assign valid_o   = r_valid;
  assign timeout_o = r_timeout;
  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_joy_sample_framer.sv
// Randomized self-checking bench for joy_sample_framer against a cycle-timeline model.
// Honours JOY_CENTER_CAL_EN in the reference model when it is defined.
module tb_joy_sample_framer;

  localparam int TMO = 100;
  localparam int SET = 16;

  logic       clk_i;
  logic       rst_i;
  logic       ready_i;
  logic [7:0] byte_i;
  logic       sel_o;
  logic [7:0] vx_o;
  logic [7:0] vy_o;
  logic       valid_o;
  logic       timeout_o;
  logic [7:0] err_cnt_o;

  joy_sample_framer #(
    .TIMEOUT_CYC (TMO),
    .SETTLE_CYC  (SET),
    .CENTER      (8'h80)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .byte_i    (byte_i),
    .ready_i   (ready_i),
    .sel_o     (sel_o),
    .vx_o      (vx_o),
    .vy_o      (vy_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o),
    .err_cnt_o (err_cnt_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clk_i) cyc <= cyc + 1;

  // Scheduled ready_i rises, each held high for four cycles.
  typedef struct {
    int         r;
    logic [7:0] b;
  } rise_t;
  rise_t sched[$];
  int    lowerAt = -1;
  int    lastR = -100;

  initial begin
    ready_i = 1'b0;
    byte_i  = 8'h00;
    forever begin
      @(posedge clk_i);
      #1;
      if (lowerAt == cyc) begin
        ready_i = 1'b0;
        byte_i  = 8'($urandom);
      end
      if (sched.size() > 0 && sched[0].r == cyc) begin
        byte_i  = sched[0].b;
        ready_i = 1'b1;
        lowerAt = cyc + 4;
        void'(sched.pop_front());
      end
    end
  end

  // Pulse counters catch spurious strobes between checkpoints.
  int validSeen = 0;
  int tmoSeen = 0;
  always @(negedge clk_i) begin
    if (valid_o === 1'b1) validSeen <= validSeen + 1;
    if (timeout_o === 1'b1) tmoSeen <= tmoSeen + 1;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model state
  int         e;
  logic [7:0] expVx = 8'h80;
  logic [7:0] expVy = 8'h80;
  int         expErr = 0;
  int         expValidCnt = 0;
  int         expTmoCnt = 0;
  logic [7:0] xHold = 8'h00;
  bit         calDone = 1'b0;
  int         offX = 0;
  int         offY = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h cycle=%0d", tag, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [7:0] b);
    rise_t t;
    t.r = r;
    t.b = b;
    sched.push_back(t);
    lastR = r;
  endtask

  task automatic gotoCycle(input int c);
    while (cyc < c) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  function automatic logic [7:0] clampCal(input int raw, input int off);
    int v;
    v = raw - off + 128;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  task automatic publish(input logic [7:0] x, input logic [7:0] y, output bit pub);
`ifdef JOY_CENTER_CAL_EN
    if (!calDone) begin
      offX = int'(x);
      offY = int'(y);
      calDone = 1'b1;
      pub = 1'b0;
    end else begin
      expVx = clampCal(int'(x), offX);
      expVy = clampCal(int'(y), offY);
      pub = 1'b1;
    end
`else
    expVx = x;
    expVy = y;
    pub = 1'b1;
`endif
    if (pub) expValidCnt++;
  endtask

  // mode 0: byte accepted `delay` cycles into WAIT; 1: extra byte during settle first; 2: no byte.
  task automatic runAxis(input bit isY, input int mode, input logic [7:0] val, input int delay,
                         output bit accepted);
    int w;
    int acc;
    int rIg;
    bit pub;
    w = e + SET;
    accepted = 1'b0;
    acc = 0;
    if (mode == 1) begin
      rIg = (cyc + 1 > lastR + 10) ? cyc + 1 : lastR + 10;
      if (rIg + 4 <= w) applyStimulus(rIg, 8'h55);
    end
    if (mode != 2) begin
      acc = w + delay;
      if (acc - 4 < lastR + 10) acc = lastR + 14;
      applyStimulus(acc - 4, val);
    end
    gotoCycle(w);
    checkOutput(isY ? "selY" : "selX", 32'(sel_o), 32'(isY));
    if (mode == 2) begin
      gotoCycle(w + TMO - 1);
      checkOutput("tmoPre", 32'(timeout_o), 32'd0);
      gotoCycle(w + TMO);
      expErr = (expErr < 255) ? expErr + 1 : 255;
      expTmoCnt++;
      checkOutput("tmoPulse", 32'(timeout_o), 32'd1);
      checkOutput("errCnt", 32'(err_cnt_o), 32'(expErr));
      gotoCycle(w + TMO + 1);
      checkOutput("tmoSel", 32'(sel_o), 32'd0);
      checkOutput("tmoVx", 32'(vx_o), 32'(expVx));
      checkOutput("tmoVy", 32'(vy_o), 32'(expVy));
      e = w + TMO;
    end else begin
      gotoCycle(acc);
      checkOutput("validPre", 32'(valid_o), 32'd0);
      gotoCycle(acc + 1);
      checkOutput("noTmo", 32'(timeout_o), 32'd0);
      checkOutput("selNext", 32'(sel_o), 32'(!isY));
      if (!isY) begin
        xHold = val;
        e = acc;
      end else begin
        publish(xHold, val, pub);
        checkOutput("validPulse", 32'(valid_o), 32'(pub));
        checkOutput("vx", 32'(vx_o), 32'(expVx));
        checkOutput("vy", 32'(vy_o), 32'(expVy));
        gotoCycle(acc + 2);
        checkOutput("validPost", 32'(valid_o), 32'd0);
        e = acc + 1;
      end
      accepted = 1'b1;
    end
  endtask

  task automatic runPair(input int mX, input logic [7:0] vX, input int dX,
                         input int mY, input logic [7:0] vY, input int dY);
    bit ok;
    runAxis(1'b0, mX, vX, dX, ok);
    if (ok) runAxis(1'b1, mY, vY, dY, ok);
  endtask

  task automatic resetChecks();
    checkOutput("rstSel", 32'(sel_o), 32'd0);
    checkOutput("rstVx", 32'(vx_o), 32'h80);
    checkOutput("rstVy", 32'(vy_o), 32'h80);
    checkOutput("rstErr", 32'(err_cnt_o), 32'd0);
    checkOutput("rstValid", 32'(valid_o), 32'd0);
    checkOutput("rstTmo", 32'(timeout_o), 32'd0);
  endtask

  function automatic int pickMode();
    int k;
    k = $urandom_range(0, 9);
    return (k < 6) ? 0 : (k < 8) ? 1 : 2;
  endfunction

  function automatic int pickDelay();
    int k;
    k = $urandom_range(0, 5);
    return (k == 0) ? 1 : (k == 1) ? TMO : $urandom_range(1, 30);
  endfunction

  initial begin
    bit ok;
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    resetChecks();
    @(negedge clk_i);
    rst_i = 1'b1;
    e = cyc;

    // Directed: normal pair, byte during Y settle, Y timeout, both boundary delays
    runPair(0, 8'h10, 5, 0, 8'hF0, 7);
    runPair(0, 8'h33, 3, 1, 8'hC4, 4);
    runPair(0, 8'h20, 2, 2, 8'h00, 0);
    runPair(0, 8'h6A, 1, 0, 8'h01, TMO);

    repeat (30) begin
      runPair(pickMode(), 8'($urandom), pickDelay(), pickMode(), 8'($urandom), pickDelay());
    end

    // Reset in the middle of a pair, while Y is being requested
    runAxis(1'b0, 0, 8'h44, 3, ok);
    #2;
    rst_i = 1'b0;
    #1;
    resetChecks();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    e = cyc;
    expVx = 8'h80;
    expVy = 8'h80;
    expErr = 0;
    calDone = 1'b0;

    runPair(0, 8'h78, 4, 0, 8'h88, 6);
    runPair(0, 8'h78, 9, 0, 8'h00, 2);

    // Error counter saturation
    repeat (300) runPair(2, 8'h00, 0, 0, 8'h00, 0);
    checkOutput("errSat", 32'(err_cnt_o), 32'hFF);

    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("validCount", 32'(validSeen), 32'(expValidCnt));
    checkOutput("tmoCount", 32'(tmoSeen), 32'(expTmoCnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
